// File: rtl/grostl_pkg.sv
// Shared types, constants and GF(2^8) helpers for the Groestl Q permutation.
// Holds no ports. Provides state_t, the round count, the Q row-shift offsets,
// the MixBytes circulant coefficients, the FSM encoding and byte multipliers.
package grostl_pkg;

  localparam int unsigned GROSTL512_ROUNDS = 10;
  localparam int unsigned RND_W            = 4;

  // state[c][r]: column c, row r
  typedef logic [0:7][0:7][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Row r moves left by Q_SHIFT[r] columns
  localparam int unsigned Q_SHIFT [8] = '{1, 3, 5, 7, 0, 2, 4, 6};

  // First row of circ(02,02,03,04,05,03,05,07)
  localparam logic [7:0] MIX_COEF [8] = '{8'h02, 8'h02, 8'h03, 8'h04,
                                          8'h05, 8'h03, 8'h05, 8'h07};

  // Multiply by x modulo 0x11B
  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant 1..7 using doublings only
  function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] res;
    x2 = gf_mul2(x);
    x4 = gf_mul2(x2);
    case (k)
      8'h01:   res = x;
      8'h02:   res = x2;
      8'h03:   res = x2 ^ x;
      8'h04:   res = x4;
      8'h05:   res = x4 ^ x;
      8'h06:   res = x4 ^ x2;
      8'h07:   res = x4 ^ x2 ^ x;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/grostl_add_constant_q.sv
// Groestl Q AddRoundConstant: every byte is inverted and the round number is
// folded into column 0, row 7.
// Ports: din (state in), rnd (round number 0..15), dout (state out).
module grostl_add_constant_q
  import grostl_pkg::*;
(
  input  state_t                 din,
  input  logic   [RND_W-1:0]     rnd,
  output state_t                 dout
);

  always_comb begin
    dout = '0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        dout[c][r] = din[c][r] ^ 8'hff;
      end
    end
    dout[0][7] = din[0][7] ^ 8'hff ^ 8'(rnd);
  end

endmodule

// File: rtl/grostl_sbox.sv
// AES S-box, purely combinational table lookup.
// Ports: din (byte in), dout (substituted byte).
module grostl_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/grostl_perm_q_iter.sv
// Iterative Groestl Q permutation, one full round per clock on a 512-bit state.
// Round order: AddRoundConstant(rnd), SubBytes, ShiftBytes(Q), MixBytes.
// Ports:
//   clk, reset (async, active-high)
//   start : accepted in IDLE or DONE; din is captured on that edge
//   din   : input state, din[c][r]
//   dout  : state register (intermediate during RUN, result from DONE on)
//   busy  : high in every RUN cycle
//   done  : one-cycle pulse, result on dout
//   trig  : only with GROSTL_PERM_Q_TRIGGER_EN; high in the RUN cycle of round 0
module grostl_perm_q_iter
  import grostl_pkg::*;
#(
  parameter int unsigned ROUNDS = GROSTL512_ROUNDS
)
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  state_t din,
  output state_t dout,
  output logic   busy,
  output logic   done
`ifdef GROSTL_PERM_Q_TRIGGER_EN
  ,
  output logic   trig
`endif
);

  state_t             state;
  logic [RND_W-1:0]   rnd;
  fsm_t               fsm;

  state_t             ac_out;
  logic [7:0]         sb_out [8][8];
  state_t             sh_out;
  state_t             mx_out;

  assign dout = state;

  grostl_add_constant_q u_add_constant (
    .din  (state),
    .rnd  (rnd),
    .dout (ac_out)
  );

  // SubBytes: one S-box per state byte
  for (genvar c = 0; c < 8; c++) begin : g_sb_col
    for (genvar r = 0; r < 8; r++) begin : g_sb_row
      grostl_sbox u_sbox (
        .din  (ac_out[c][r]),
        .dout (sb_out[c][r])
      );
    end
  end

  // ShiftBytes: 3-bit truncation of the column index gives the mod-8 wrap
  always_comb begin
    sh_out = '0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        sh_out[c][r] = sb_out[3'(c + Q_SHIFT[r])][r];
      end
    end
  end

  // MixBytes: out row i uses coefficient MIX_COEF[(j - i) mod 8] on input row j
  always_comb begin
    mx_out = '0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          mx_out[c][i] = mx_out[c][i] ^ gf_mul_const(sh_out[c][j], MIX_COEF[3'(j + 8 - i)]);
        end
      end
    end
  end

  // Control and state register; DONE accepts start exactly like IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
      rnd   <= '0;
      fsm   <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef GROSTL_PERM_Q_TRIGGER_EN
      trig  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef GROSTL_PERM_Q_TRIGGER_EN
      trig <= 1'b0;
`endif
      case (fsm)
        RUN: begin
          state <= mx_out;
          if (rnd == RND_W'(ROUNDS - 1)) begin
            rnd  <= '0;
            fsm  <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            rnd <= rnd + RND_W'(1);
          end
        end
        default: begin
          if (start) begin
            state <= din;
            rnd   <= '0;
            fsm   <= RUN;
            busy  <= 1'b1;
`ifdef GROSTL_PERM_Q_TRIGGER_EN
            trig  <= 1'b1;
`endif
          end else begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
